// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default size, read-out FSM
// encoding and the bit-reverse used by both the write and read sides.
package fft_pkg;

   localparam int N_LOG2_DEFAULT = 6;
   localparam int BITREV_MAX     = 16;
   localparam int SKID_DEPTH     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READING = 2'd1,
      ST_DRAIN   = 2'd2
   } seq_state_e;

   // Reverses the low nbits of v; bits above nbits come back as zero.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                    input int nbits);
      logic [BITREV_MAX-1:0] r;
      for (int i = 0; i < BITREV_MAX; i++) begin
         r[i] = v[BITREV_MAX-1-i];
      end
      return r >> (BITREV_MAX - nbits);
   endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Four-entry skid FIFO between the result-RAM read port and the output stream.
// The head is presented directly; it reads as zero while the FIFO is empty.
module out_skid_fifo
   import fft_pkg::*;
#(
   parameter int W = 38
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic         valid_o,
   output logic [W-1:0] head_o,
   output logic [2:0]   occ_o
);

   logic [W-1:0] mem_q [SKID_DEPTH];
   logic [1:0]   wr_ptr_q;
   logic [1:0]   rd_ptr_q;
   logic [2:0]   occ_q;
   logic         do_push;
   logic         do_pop;

   // A push into a full FIFO is accepted only when the head leaves on the same edge.
   assign do_pop  = pop_i && (occ_q != 3'd0);
   assign do_push = push_i && ((occ_q != 3'(SKID_DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 2'd1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         case ({do_push, do_pop})
            2'b10:   occ_q <= occ_q + 3'd1;
            2'b01:   occ_q <= occ_q - 3'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign valid_o = (occ_q != 3'd0);
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign occ_o   = occ_q;

endmodule

// File: rtl/output_sequencer.sv
// Read-out sequencer: walks the result RAM (optionally in bit-reversed order)
// and streams the frame in natural order over valid/ready, then pulses dataend.
module output_sequencer
   import fft_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEFAULT,
   parameter int DATA_W = 32,
   parameter int BITREV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fftdone,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [N_LOG2-1:0] out_index,
   output logic              out_last,
   output logic              dataend,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshake: a word moves when out_valid && out_ready on a rising edge;
   // once raised, out_valid and its payload hold until that transfer (or rst).

   localparam int                N        = 1 << N_LOG2;
   localparam int                CW       = N_LOG2 + 1;
   localparam logic [CW-1:0]     LAST_IDX = CW'(N - 1);
   localparam int                FW       = DATA_W + N_LOG2;

   seq_state_e          state_q;
   logic [CW-1:0]       cnt_q;
   logic                rd_en_q;
   logic [N_LOG2-1:0]   rd_addr_q;
   logic [N_LOG2-1:0]   rd_idx_q;
   logic                inflight_q;
   logic [N_LOG2-1:0]   inflight_idx_q;
   logic                dataend_q;
   logic                busy_q;

   logic [3:0]          pending;
   logic                start;
   logic                issue;
   logic [CW-1:0]       issue_idx;
   logic                last_issue;
   logic [N_LOG2-1:0]   addr_nat;
   logic [N_LOG2-1:0]   addr_rev;
   logic                last_xfer;

   logic                fifo_valid;
   logic [FW-1:0]       fifo_head;
   logic [2:0]          fifo_occ;

   // Credit counts queued words plus the read on the RAM port and the one
   // whose data is on rd_data now, so the FIFO can never be over-filled.
   always_comb begin
      pending    = {1'b0, fifo_occ} + {3'b000, inflight_q} + {3'b000, rd_en_q};
      start      = (state_q == ST_IDLE) && fftdone;
      issue      = start || ((state_q == ST_READING) && (pending < 4'(SKID_DEPTH)));
      issue_idx  = start ? '0 : cnt_q;
      last_issue = (issue_idx == LAST_IDX);
      addr_nat   = issue_idx[N_LOG2-1:0];
      addr_rev   = N_LOG2'(bitrev(BITREV_MAX'(addr_nat), N_LOG2));
      last_xfer  = out_valid && out_ready && out_last;
   end

   // Index 0 is issued on the entry edge itself, so the counter is loaded
   // with 1 there; this is the cleared counter already advanced by one read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         rd_en_q        <= 1'b0;
         rd_addr_q      <= '0;
         rd_idx_q       <= '0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         dataend_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         rd_en_q        <= issue;
         inflight_q     <= rd_en_q;
         inflight_idx_q <= rd_idx_q;
         dataend_q      <= 1'b0;
         if (issue) begin
            rd_addr_q <= (BITREV != 0) ? addr_rev : addr_nat;
            rd_idx_q  <= addr_nat;
            cnt_q     <= issue_idx + CW'(1);
         end
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= last_issue ? ST_DRAIN : ST_READING;
                  busy_q  <= 1'b1;
               end
            end
            ST_READING: begin
               if (issue && last_issue) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_xfer) begin
                  state_q   <= ST_IDLE;
                  dataend_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   out_skid_fifo #(
      .W (FW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i ({inflight_idx_q, rd_data}),
      .pop_i       (out_valid && out_ready),
      .valid_o     (fifo_valid),
      .head_o      (fifo_head),
      .occ_o       (fifo_occ)
   );

   assign out_valid = fifo_valid;
   assign out_data  = fifo_head[DATA_W-1:0];
   assign out_index = fifo_head[DATA_W +: N_LOG2];
   assign out_last  = fifo_valid && (out_index == N_LOG2'(N - 1));

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign dataend   = dataend_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer: cycle-table checks of the first frame,
// a stream scoreboard, and hand-written stall, reset, retrigger and BITREV=0 runs.
module tb_output_sequencer;

   localparam int NL = 6;
   localparam int DW = 32;
   localparam int NP = 64;
   localparam int WW = 1 + NL + DW;

   logic          clk;
   logic          rst;
   logic          fftdone, fftdone0;
   logic          rd_en, rd_en0;
   logic [NL-1:0] rd_addr, rd_addr0;
   logic [DW-1:0] rd_data, rd_data0;
   logic          out_valid, out_valid0;
   logic          out_ready, out_ready0;
   logic [DW-1:0] out_data, out_data0;
   logic [NL-1:0] out_index, out_index0;
   logic          out_last, out_last0;
   logic          dataend, dataend0;
   logic          busy, busy0;
   logic [1:0]    dbg_state, dbg_state0;

   logic [DW-1:0] ram [NP];

   int checks = 0;
   int errors = 0;
   logic [WW-1:0] exp_q[$];
   logic          mon_en = 1'b0;
   logic          prev_stall = 1'b0;
   logic [WW-1:0] prev_word = '0;
   int xfer_cnt = 0;
   int dataend_cnt = 0;
   int rd_cnt = 0;

   output_sequencer #(.N_LOG2(NL), .DATA_W(DW), .BITREV(1)) dut (
      .clk(clk), .rst(rst), .fftdone(fftdone), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last),
      .dataend(dataend), .busy(busy), .dbg_state(dbg_state)
   );

   output_sequencer #(.N_LOG2(NL), .DATA_W(DW), .BITREV(0)) dut0 (
      .clk(clk), .rst(rst), .fftdone(fftdone0), .rd_en(rd_en0), .rd_addr(rd_addr0),
      .rd_data(rd_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_data(out_data0), .out_index(out_index0), .out_last(out_last0),
      .dataend(dataend0), .busy(busy0), .dbg_state(dbg_state0)
   );

   // ---------------- clock / reset / RAM model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_data  <= ram[rd_addr];
      rd_data0 <= ram[rd_addr0];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [NL-1:0] rev6(input logic [NL-1:0] v);
      logic [NL-1:0] r;
      for (int b = 0; b < NL; b++) r[NL-1-b] = v[b];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_ram(input int seed);
      for (int a = 0; a < NP; a++) begin
         ram[a] = (seed == 0) ? 32'(a) : (32'(a) * 32'h0001_0203) ^ (32'(seed) * 32'h9E37_79B1);
      end
   endtask

   task automatic start_frame();
      exp_q.delete();
      for (int i = 0; i < NP; i++) begin
         exp_q.push_back({(i == NP - 1), NL'(i), ram[rev6(NL'(i))]});
      end
      @(posedge clk); #1 fftdone = 1'b1;
      @(posedge clk); #1 fftdone = 1'b0;
   endtask

   task automatic wait_xfers(input int target, input int budget);
      int n = 0;
      while (xfer_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("xfer_target_reached", 64'(xfer_cnt >= target), 64'd1);
   endtask

   task automatic wait_done(input int db, input int budget);
      int n = 0;
      while (dataend_cnt == db && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("dataend_count", 64'(dataend_cnt - db), 64'd1);
   endtask

   // ---------------- scoreboard / stream monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (mon_en) begin
            if (prev_stall) begin
               check("hold_while_stalled", {out_valid, out_last, out_index, out_data}, {1'b1, prev_word});
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_word: got index %0d data %0h with none expected", out_index, out_data);
               end else begin
                  check("stream_word", {out_last, out_index, out_data}, exp_q.pop_front());
               end
               xfer_cnt++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_last, out_index, out_data};
         if (dataend) dataend_cnt++;
         if (rd_en) rd_cnt++;
      end
   end

   // ---------------- cycle table for the first frame ----------------
   typedef struct {
      int            cyc;
      logic          ready;
      logic          rd_en;
      logic [NL-1:0] addr;
      logic          valid;
      logic [NL-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
      logic          dataend;
      logic          busy;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl [NV];

   function automatic vec_t mk(input int c, input logic re, input int ad, input logic v,
                               input int ix, input int d, input logic l, input logic de,
                               input logic b);
      vec_t t;
      t.cyc = c; t.ready = 1'b1; t.rd_en = re; t.addr = NL'(ad); t.valid = v;
      t.idx = NL'(ix); t.data = DW'(d); t.last = l; t.dataend = de; t.busy = b;
      return t;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int xb, db, rb, n, de0, x0;
      logic [NL-1:0] exp_addr0, exp_idx0;
      logic gap_pending;

      rst = 1'b1; fftdone = 1'b0; out_ready = 1'b1; fftdone0 = 1'b0; out_ready0 = 1'b1;
      fill_ram(0);
      //              cyc rd addr val idx data last de busy   (RAM[a]=a, so data = bitrev(idx))
      tbl[0] = mk( 1, 1,  0, 0,  0,  0, 0, 0, 1);
      tbl[1] = mk( 2, 1, 32, 0,  0,  0, 0, 0, 1);
      tbl[2] = mk( 3, 1, 16, 1,  0,  0, 0, 0, 1);
      tbl[3] = mk( 4, 1, 48, 1,  1, 32, 0, 0, 1);
      tbl[4] = mk(33, 1,  1, 1, 30, 30, 0, 0, 1);
      tbl[5] = mk(64, 1, 63, 1, 61, 47, 0, 0, 1);
      tbl[6] = mk(65, 0,  0, 1, 62, 31, 0, 0, 1);
      tbl[7] = mk(66, 0,  0, 1, 63, 63, 1, 0, 1);
      tbl[8] = mk(67, 0,  0, 0,  0,  0, 0, 1, 0);
      tbl[9] = mk(68, 0,  0, 0,  0,  0, 0, 0, 0);

      // Reset state of both instances
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {rd_en, rd_addr, out_valid, out_data, out_index, out_last, dataend, busy, dbg_state}, 64'd0);
      check("reset_outputs_b0", {rd_en0, rd_addr0, out_valid0, out_data0, out_index0, out_last0, dataend0, busy0}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      mon_en = 1'b1;

      // Test 1: first frame, ready held high, cycle-exact table
      xb = xfer_cnt; db = dataend_cnt;
      start_frame();
      for (int c = 1; c <= 68; c++) begin
         for (int j = 0; j < NV; j++) if (tbl[j].cyc == c) out_ready = tbl[j].ready;
         @(negedge clk);
         for (int j = 0; j < NV; j++) begin
            if (tbl[j].cyc == c) begin
               check($sformatf("t1_ctrl_c%0d", c), {rd_en, out_valid, dataend, busy},
                     {tbl[j].rd_en, tbl[j].valid, tbl[j].dataend, tbl[j].busy});
               if (tbl[j].rd_en) check($sformatf("t1_addr_c%0d", c), rd_addr, tbl[j].addr);
               if (tbl[j].valid) check($sformatf("t1_word_c%0d", c), {out_last, out_index, out_data},
                                       {tbl[j].last, tbl[j].idx, tbl[j].data});
            end
         end
         @(posedge clk); #1;
      end
      check("t1_xfers", 64'(xfer_cnt - xb), 64'd64);
      check("t1_dataend", 64'(dataend_cnt - db), 64'd1);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Test 2: random back-pressure
      fill_ram(1);
      xb = xfer_cnt; db = dataend_cnt; n = 0;
      start_frame();
      while (dataend_cnt == db && n < 3000) begin
         @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      out_ready = 1'b1;
      wait_done(db, 10);
      check("t2_xfers", 64'(xfer_cnt - xb), 64'd64);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Test 3: long stall right after start
      fill_ram(2);
      out_ready = 1'b0;
      xb = xfer_cnt; db = dataend_cnt; rb = rd_cnt;
      start_frame();
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t3_reads_issued", 64'(rd_cnt - rb), 64'd4);
      check("t3_stalled_state", {rd_en, out_valid, out_index, dbg_state}, {1'b0, 1'b1, NL'(0), 2'd1});
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done(db, 300);
      check("t3_xfers", 64'(xfer_cnt - xb), 64'd64);

      // Test 4: reset at transfer 30, then a clean frame
      fill_ram(3);
      xb = xfer_cnt; db = dataend_cnt;
      start_frame();
      wait_xfers(xb + 30, 300);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("t4_outputs_after_rst", {rd_en, rd_addr, out_valid, out_data, out_index, out_last, dataend, busy, dbg_state}, 64'd0);
      repeat (100) @(negedge clk);
      check("t4_no_dataend", 64'(dataend_cnt - db), 64'd0);
      check("t4_idle", {busy, out_valid, rd_en}, 64'd0);
      fill_ram(4);
      xb = xfer_cnt; db = dataend_cnt;
      start_frame();
      wait_done(db, 300);
      check("t4_clean_xfers", 64'(xfer_cnt - xb), 64'd64);

      // Test 5: fftdone pulsed again mid-frame is ignored
      fill_ram(5);
      xb = xfer_cnt; db = dataend_cnt; rb = rd_cnt;
      start_frame();
      wait_xfers(xb + 10, 300);
      @(posedge clk); #1 fftdone = 1'b1;
      @(posedge clk); #1 fftdone = 1'b0;
      wait_done(db, 300);
      repeat (20) @(negedge clk);
      check("t5_xfers", 64'(xfer_cnt - xb), 64'd64);
      check("t5_reads", 64'(rd_cnt - rb), 64'd64);
      check("t5_single_dataend", 64'(dataend_cnt - db), 64'd1);
      check("t5_idle_after", {busy, dbg_state}, 64'd0);

      // Test 6: BITREV=0 instance, fftdone held high, back-to-back frames
      fill_ram(6);
      exp_addr0 = '0; exp_idx0 = '0; de0 = 0; x0 = 0; n = 0; gap_pending = 1'b0;
      @(posedge clk); #1 fftdone0 = 1'b1;
      while (de0 < 2 && n < 400) begin
         @(negedge clk);
         n++;
         if (gap_pending) begin
            check("t6_no_gap", {rd_en0, busy0}, 2'b11);
            gap_pending = 1'b0;
         end
         if (rd_en0) begin
            check("t6_rd_addr", rd_addr0, exp_addr0);
            exp_addr0 = exp_addr0 + 1'b1;
         end
         if (out_valid0 && out_ready0) begin
            check("t6_word", {out_last0, out_index0, out_data0},
                  {(exp_idx0 == NL'(NP - 1)), exp_idx0, ram[exp_idx0]});
            exp_idx0 = exp_idx0 + 1'b1;
            x0++;
         end
         if (dataend0) begin
            de0++;
            gap_pending = 1'b1;
         end
      end
      @(negedge clk);
      check("t6_restart", {rd_en0, rd_addr0}, {1'b1, NL'(0)});
      check("t6_frames", 64'(de0), 64'd2);
      check("t6_xfers", 64'(x0), 64'd128);
      fftdone0 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
